mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : Two-master round-robin arbiter in front of a single native
//             memory-bus slave (RAM plus peripheral decode). Master 0 is the
//             CPU core, master 1 the loader/debug port. A granted transfer
//             that waits too long on the slave is aborted with an error
//             response, a one-cycle timeout_err pulse and error bookkeeping.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TIMEOUT_CYCLES : wait cycles allowed in a grant before a forced abort
//                     (2..65535)
//    ERR_RDATA      : read data returned to the master on an aborted transfer
//  Ports
//    clk, resetn                        : clock, asynchronous active-low reset
//    m0_valid/instr/addr/wdata/wstrb    : master 0 request
//    m0_ready/rdata                     : master 0 response
//    m1_valid/instr/addr/wdata/wstrb    : master 1 request
//    m1_ready/rdata                     : master 1 response
//    s_valid/instr/addr/wdata/wstrb     : request towards the shared slave
//    s_ready/rdata                      : slave response
//    timeout_err                        : one-cycle pulse while aborting
//    err_addr                           : address of most recent abort
//    err_count                          : saturating abort count
// ============================================================================
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic        timeout_err,
    output logic [31:0] err_addr,
    output logic [7:0]  err_count
);

    localparam logic [15:0] c_wait_last = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2,
        ST_ABORT  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_last_grant;
    logic [15:0] r_wait_cnt;
    logic [31:0] r_err_addr;
    logic [7:0]  r_err_count;

    // r_last_grant is updated on entry to a grant, so while in GRANTx or
    // ABORT it names the master that currently owns the bus.
    logic        w_granted;
    logic        w_own_valid;
    logic        w_own_instr;
    logic [31:0] w_own_addr;
    logic [31:0] w_own_wdata;
    logic [3:0]  w_own_wstrb;

    assign w_granted   = (r_state == ST_GRANT0) || (r_state == ST_GRANT1);
    assign w_own_valid = r_last_grant ? m1_valid : m0_valid;
    assign w_own_instr = r_last_grant ? m1_instr : m0_instr;
    assign w_own_addr  = r_last_grant ? m1_addr  : m0_addr;
    assign w_own_wdata = r_last_grant ? m1_wdata : m0_wdata;
    assign w_own_wstrb = r_last_grant ? m1_wstrb : m0_wstrb;

    // Masters hold valid until they see ready, so a request raised while the
    // bus is busy is simply still present at the next IDLE cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (m0_valid && m1_valid) begin
                    w_state_next = r_last_grant ? ST_GRANT0 : ST_GRANT1;
                end else if (m0_valid) begin
                    w_state_next = ST_GRANT0;
                end else if (m1_valid) begin
                    w_state_next = ST_GRANT1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                // Completion (or withdrawal) takes priority over the timeout,
                // so a ready on the terminal wait cycle finishes normally.
                if (!w_own_valid || s_ready) begin
                    w_state_next = ST_IDLE;
                end else if (r_wait_cnt == c_wait_last) begin
                    w_state_next = ST_ABORT;
                end
            end
            ST_ABORT: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        s_valid     = 1'b0;
        s_instr     = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        m0_ready    = 1'b0;
        m0_rdata    = '0;
        m1_ready    = 1'b0;
        m1_rdata    = '0;
        timeout_err = 1'b0;
        if (w_granted) begin
            s_valid = w_own_valid;
            s_instr = w_own_instr;
            s_addr  = w_own_addr;
            s_wdata = w_own_wdata;
            s_wstrb = w_own_wstrb;
            if (r_last_grant) begin
                m1_ready = s_ready;
                m1_rdata = s_rdata;
            end else begin
                m0_ready = s_ready;
                m0_rdata = s_rdata;
            end
        end else if (r_state == ST_ABORT) begin
            timeout_err = 1'b1;
            if (r_last_grant) begin
                m1_ready = 1'b1;
                m1_rdata = ERR_RDATA;
            end else begin
                m0_ready = 1'b1;
                m0_rdata = ERR_RDATA;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_wait_cnt   <= '0;
            r_err_addr   <= '0;
            r_err_count  <= '0;
        end else begin
            r_state <= w_state_next;

            if (r_state == ST_IDLE) begin
                if (w_state_next == ST_GRANT0) begin
                    r_last_grant <= 1'b0;
                end else if (w_state_next == ST_GRANT1) begin
                    r_last_grant <= 1'b1;
                end
            end

            // Held at zero outside a grant, which clears it on grant entry.
            if (w_granted) begin
                if (!s_ready) begin
                    r_wait_cnt <= r_wait_cnt + 16'd1;
                end
            end else begin
                r_wait_cnt <= '0;
            end

            if (r_state == ST_ABORT) begin
                r_err_addr <= w_own_addr;
                if (r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
        end
    end

    assign err_addr  = r_err_addr;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_arbiter
//  Purpose  : Self-checking bench for mem_bus_arbiter. Directed scenarios
//             followed by randomized master/slave traffic, all compared each
//             cycle against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int          c_to   = 8;
    localparam logic [31:0] c_errd = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m0_instr, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_instr, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_valid, s_instr, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        timeout_err;
    logic [31:0] err_addr;
    logic [7:0]  err_count;

    mem_bus_arbiter #(
        .TIMEOUT_CYCLES (c_to),
        .ERR_RDATA      (c_errd)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .m0_valid    (m0_valid),
        .m0_instr    (m0_instr),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_wstrb    (m0_wstrb),
        .m0_ready    (m0_ready),
        .m0_rdata    (m0_rdata),
        .m1_valid    (m1_valid),
        .m1_instr    (m1_instr),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_wstrb    (m1_wstrb),
        .m1_ready    (m1_ready),
        .m1_rdata    (m1_rdata),
        .s_valid     (s_valid),
        .s_instr     (s_instr),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_ready     (s_ready),
        .s_rdata     (s_rdata),
        .timeout_err (timeout_err),
        .err_addr    (err_addr),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: who owns the bus, whether it is serving or aborting,
    // how long it has waited, who was served last, and error bookkeeping.
    int          md_busy;    // 0 free, 1 serving, 2 aborting
    int          md_own;
    int          md_waited;
    int          md_last;
    int          md_errs;
    logic [31:0] md_eaddr;
    logic        exp_r0, exp_r1;
    int          rdy_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic mv(int k);       return k == 1 ? m1_valid : m0_valid; endfunction
    function automatic logic mi(int k);       return k == 1 ? m1_instr : m0_instr; endfunction
    function automatic logic [31:0] ma(int k); return k == 1 ? m1_addr  : m0_addr;  endfunction
    function automatic logic [31:0] mw(int k); return k == 1 ? m1_wdata : m0_wdata; endfunction
    function automatic logic [3:0]  ms(int k); return k == 1 ? m1_wstrb : m0_wstrb; endfunction

    task automatic model_reset();
        md_busy   = 0;
        md_own    = 0;
        md_waited = 0;
        md_last   = 1;
        md_errs   = 0;
        md_eaddr  = '0;
    endtask

    task automatic model_clock();
        if (!resetn) begin
            model_reset();
        end else if (md_busy == 0) begin
            if (m0_valid || m1_valid) begin
                if (m0_valid && m1_valid) md_own = (md_last == 0) ? 1 : 0;
                else                      md_own = m1_valid ? 1 : 0;
                md_busy   = 1;
                md_waited = 0;
                md_last   = md_own;
            end
        end else if (md_busy == 1) begin
            if (!mv(md_own) || s_ready)   md_busy = 0;
            else if (md_waited == c_to - 1) md_busy = 2;
            else                            md_waited++;
        end else begin
            md_errs  = (md_errs < 255) ? md_errs + 1 : 255;
            md_eaddr = ma(md_own);
            md_busy  = 0;
        end
    endtask

    task automatic compare();
        logic        e_sv, e_si, e_r0, e_r1, e_te;
        logic [31:0] e_sa, e_sw, e_d0, e_d1;
        logic [3:0]  e_ss;
        e_sv = 0; e_si = 0; e_sa = '0; e_sw = '0; e_ss = '0;
        e_r0 = 0; e_r1 = 0; e_d0 = '0; e_d1 = '0; e_te = 0;
        if (md_busy == 1) begin
            e_sv = mv(md_own); e_si = mi(md_own); e_sa = ma(md_own);
            e_sw = mw(md_own); e_ss = ms(md_own);
            if (md_own == 0) begin e_r0 = s_ready; e_d0 = s_rdata; end
            else             begin e_r1 = s_ready; e_d1 = s_rdata; end
        end else if (md_busy == 2) begin
            e_te = 1;
            if (md_own == 0) begin e_r0 = 1; e_d0 = c_errd; end
            else             begin e_r1 = 1; e_d1 = c_errd; end
        end
        chk("s_valid",     32'(s_valid),     32'(e_sv));
        chk("s_instr",     32'(s_instr),     32'(e_si));
        chk("s_addr",      s_addr,           e_sa);
        chk("s_wdata",     s_wdata,          e_sw);
        chk("s_wstrb",     32'(s_wstrb),     32'(e_ss));
        chk("m0_ready",    32'(m0_ready),    32'(e_r0));
        chk("m0_rdata",    m0_rdata,         e_d0);
        chk("m1_ready",    32'(m1_ready),    32'(e_r1));
        chk("m1_rdata",    m1_rdata,         e_d1);
        chk("timeout_err", 32'(timeout_err), 32'(e_te));
        chk("err_addr",    err_addr,         md_eaddr);
        chk("err_count",   32'(err_count),   32'(md_errs));
        exp_r0 = e_r0;
        exp_r1 = e_r1;
        if (m0_ready === 1'b1) rdy_q.push_back(0);
        if (m1_ready === 1'b1) rdy_q.push_back(1);
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic rand_drive();
        if (m0_valid && exp_r0)                         m0_valid = 0;
        else if (m0_valid && $urandom_range(0, 39) == 0) m0_valid = 0;
        else if (!m0_valid && $urandom_range(0, 2) == 0) begin
            m0_valid = 1; m0_addr = $urandom; m0_wdata = $urandom;
            m0_wstrb = 4'($urandom_range(0, 15)); m0_instr = 1'($urandom_range(0, 1));
        end
        if (m1_valid && exp_r1)                         m1_valid = 0;
        else if (m1_valid && $urandom_range(0, 39) == 0) m1_valid = 0;
        else if (!m1_valid && $urandom_range(0, 2) == 0) begin
            m1_valid = 1; m1_addr = $urandom; m1_wdata = $urandom;
            m1_wstrb = 4'($urandom_range(0, 15)); m1_instr = 1'($urandom_range(0, 1));
        end
        s_ready = ($urandom_range(0, 5) == 0);
        s_rdata = $urandom;
    endtask

    initial begin
        m0_valid = 0; m0_instr = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 0; m1_instr = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_ready = 0; s_rdata = '0;
        exp_r0 = 0; exp_r1 = 0;
        resetn = 1;
        #1 resetn = 0;
        model_reset();
        repeat (3) tick();
        resetn = 1;

        // Simultaneous requests, repeated: grants alternate starting with m0.
        rdy_q.delete();
        m0_valid = 1; m0_addr = 32'h0000_0100;
        m1_valid = 1; m1_addr = 32'h0000_0200;
        s_ready = 1; s_rdata = 32'h0000_0055;
        repeat (8) tick();
        m0_valid = 0; m1_valid = 0; s_ready = 0;
        tick();
        chk("rr_count", rdy_q.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), rdy_q[i], i % 2);

        // m0 read, slave answers after three wait cycles.
        rdy_q.delete();
        m0_valid = 1; m0_instr = 0; m0_addr = 32'h0000_1000; m0_wdata = '0; m0_wstrb = 4'b0000;
        tick();
        #1 chk("rd_svalid_lat", 32'(s_valid), 1);
        chk("rd_saddr", s_addr, 32'h0000_1000);
        repeat (3) tick();
        s_ready = 1; s_rdata = 32'h1234_5678;
        #1 chk("rd_m0_ready", 32'(m0_ready), 1);
        chk("rd_m0_rdata", m0_rdata, 32'h1234_5678);
        chk("rd_m1_ready", 32'(m1_ready), 0);
        tick();
        m0_valid = 0; s_ready = 0;
        tick();
        chk("rd_ready_pulses", rdy_q.size(), 1);

        // m1 write, slave never ready: abort after the timeout.
        m1_valid = 1; m1_instr = 0; m1_addr = 32'h0000_8070; m1_wdata = 32'hA5A5_0F0F; m1_wstrb = 4'b1111;
        tick();
        repeat (c_to) tick();
        #1 chk("to_m1_ready", 32'(m1_ready), 1);
        chk("to_m1_rdata", m1_rdata, c_errd);
        chk("to_pulse", 32'(timeout_err), 1);
        chk("to_svalid", 32'(s_valid), 0);
        tick();
        m1_valid = 0;
        #1 chk("to_err_addr", err_addr, 32'h0000_8070);
        chk("to_err_count", 32'(err_count), 1);
        chk("to_pulse_end", 32'(timeout_err), 0);
        tick();

        // Slave ready on the terminal wait cycle: normal completion wins.
        m0_valid = 1; m0_addr = 32'h0000_2000; m0_wstrb = 4'b0011; m0_wdata = 32'h0000_BEEF;
        tick();
        repeat (c_to - 1) tick();
        s_ready = 1; s_rdata = 32'hCAFE_0001;
        #1 chk("edge_m0_ready", 32'(m0_ready), 1);
        chk("edge_m0_rdata", m0_rdata, 32'hCAFE_0001);
        chk("edge_no_abort", 32'(timeout_err), 0);
        tick();
        m0_valid = 0; s_ready = 0;
        tick();
        #1 chk("edge_err_count", 32'(err_count), 1);
        tick();

        // Reset mid-GRANT1 with m0 pending; m0 wins after release.
        rdy_q.delete();
        m1_valid = 1; m1_addr = 32'h0000_3000; m1_wstrb = 4'b0000;
        tick();
        m0_valid = 1; m0_addr = 32'h0000_4000; m0_wstrb = 4'b0000;
        #1 chk("rst_pre_svalid", 32'(s_valid), 1);
        chk("rst_pre_saddr", s_addr, 32'h0000_3000);
        s_ready = 1; s_rdata = 32'h7777_7777;
        resetn = 0;
        model_reset();
        #1 chk("rst_svalid", 32'(s_valid), 0);
        chk("rst_saddr", s_addr, 0);
        chk("rst_m1_ready", 32'(m1_ready), 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        chk("rst_err_count", 32'(err_count), 0);
        repeat (2) tick();
        resetn = 1;
        tick();
        #1 chk("rst_first_saddr", s_addr, 32'h0000_4000);
        tick();
        m0_valid = 0;
        tick();
        tick();
        m1_valid = 0; s_ready = 0;
        tick();
        chk("rst_order_count", rdy_q.size(), 2);
        chk("rst_order_first", rdy_q[0], 0);
        chk("rst_order_second", rdy_q[1], 1);

        // Randomized traffic.
        repeat (1500) begin
            rand_drive();
            tick();
        end
        m0_valid = 0; m1_valid = 0; s_ready = 0;
        repeat (3) tick();

        // Back-to-back forced timeouts: err_count saturates.
        m0_valid = 1; m0_addr = 32'h0000_9000; m0_wstrb = 4'b1111; s_ready = 0;
        repeat (300 * (c_to + 2) + 20) tick();
        m0_valid = 0;
        repeat (2) tick();
        #1 chk("sat_err_count", 32'(err_count), 255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
